cb_dina_seq_map: RTL

//  Parametrised successor of the CB write-data lane mapper. On a start command it snapshots

---
 rtl/cb_dina_pkg.sv | 24 ++
 rtl/cb_lane_place.sv | 29 ++
 rtl/cb_dina_seq_map.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cb_dina_pkg.sv
// Shared definitions for the CB write-data lane mapper: mode codes,
// scalar source ordering and FSM state encoding.
package cb_dina_pkg;

   localparam logic [1:0] CB_DINA_NONE    = 2'b00;
   localparam logic [1:0] CB_DINA_GENERIC = 2'b01;
   localparam logic [1:0] CB_DINA_XYXITA  = 2'b10;
   localparam logic [1:0] CB_DINA_LXLY    = 2'b11;

   localparam int SRC_X    = 0;
   localparam int SRC_Y    = 1;
   localparam int SRC_XITA = 2;
   localparam int SRC_LKX  = 3;
   localparam int SRC_LKY  = 4;

   // fixed-mode element counts derived from the source ordering
   localparam int XYXITA_CNT = SRC_XITA - SRC_X + 32'sd1;
   localparam int LXLY_CNT   = SRC_LKY - SRC_LKX + 32'sd1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EMIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/cb_lane_place.sv
// Places one data word onto a single lane of an L-lane bus and
// produces the matching one-hot write enable.
module cb_lane_place #(
   parameter int L       = 4,
   parameter int DW      = 32,
   parameter int LANE_DW = 2
) (
   input  logic [DW-1:0]      word,
   input  logic [LANE_DW-1:0] lane,
   output logic [L*DW-1:0]    bus,
   output logic [L-1:0]       en
);

   // lane decode: selected lane gets the word, all others stay zero
   always_comb begin
      bus = '0;
      en  = '0;
      for (int i = 0; i < L; i++) begin
         if (LANE_DW'(i) == lane) begin
            bus[i*DW +: DW] = word;
            en[i]           = 1'b1;
         end else begin
            bus[i*DW +: DW] = '0;
            en[i]           = 1'b0;
         end
      end
   end

endmodule

// File: rtl/cb_dina_seq_map.sv
// Snapshots scalar EKF sources on a start command and streams them one
// element per beat onto an L-lane CB write bus with valid/ready handshake.
module cb_dina_seq_map
   import cb_dina_pkg::*;
#(
   parameter int L       = 4,
   parameter int RSA_DW  = 32,
   parameter int NSRC    = 5,
   parameter int MODE_DW = 2,
   parameter int IDX_DW  = $clog2(NSRC + 1),
   parameter int LANE_DW = (L > 1) ? $clog2(L) : 1
) (
   input  logic                     clk,
   input  logic                     sys_rst,
   input  logic                     start,
   input  logic [MODE_DW-1:0]       mode,
   input  logic [IDX_DW-1:0]        gen_base,
   input  logic [IDX_DW-1:0]        gen_cnt,
   input  logic [NSRC*RSA_DW-1:0]   src_vec,
   output logic                     busy,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [L*RSA_DW-1:0]      CB_dina,
   output logic [L-1:0]             CB_wea,
   output logic [LANE_DW-1:0]       lane_idx,
   output logic                     done
);

   logic [1:0]               state_r;
   logic [NSRC*RSA_DW-1:0]   snap_r;
   logic [IDX_DW-1:0]        base_r;
   logic [IDX_DW-1:0]        cnt_r;
   logic [IDX_DW-1:0]        k_r;
   logic [LANE_DW-1:0]       lane_r;
   logic                     busy_r;
   logic                     out_valid_r;
   logic [L*RSA_DW-1:0]      dina_r;
   logic [L-1:0]             wea_r;
   logic [LANE_DW-1:0]       lane_idx_r;
   logic                     done_r;

   logic                     mode_ok_s;
   logic [IDX_DW-1:0]        base_s;
   logic [IDX_DW-1:0]        eff_cnt_s;
   logic [LANE_DW-1:0]       lane_next_s;
   logic [RSA_DW-1:0]        place_word_s;
   logic [LANE_DW-1:0]       place_lane_s;
   logic [L*RSA_DW-1:0]      place_bus_s;
   logic [L-1:0]             place_en_s;
   logic                     last_beat_s;

   // out-of-range indices yield zero rather than wrapping into a neighbour
   function automatic logic [RSA_DW-1:0] pick(input logic [NSRC*RSA_DW-1:0] v,
                                              input logic [IDX_DW-1:0] idx);
      logic [RSA_DW-1:0] w;
      w = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (IDX_DW'(i) == idx) begin
            w = v[i*RSA_DW +: RSA_DW];
         end
      end
      return w;
   endfunction

   assign mode_ok_s   = (mode != MODE_DW'(CB_DINA_NONE));
   assign lane_next_s = (lane_r == LANE_DW'(L - 1)) ? '0 : lane_r + LANE_DW'(1);
   assign last_beat_s = (k_r == cnt_r - IDX_DW'(1));

   // mode table: window base and effective element count
   always_comb begin
      base_s    = '0;
      eff_cnt_s = '0;
      case (mode)
         MODE_DW'(CB_DINA_XYXITA): begin
            base_s    = IDX_DW'(SRC_X);
            eff_cnt_s = IDX_DW'(XYXITA_CNT);
         end
         MODE_DW'(CB_DINA_LXLY): begin
            base_s    = IDX_DW'(SRC_LKX);
            eff_cnt_s = IDX_DW'(LXLY_CNT);
         end
         MODE_DW'(CB_DINA_GENERIC): begin
            base_s = gen_base;
            if (gen_base >= IDX_DW'(NSRC)) begin
               eff_cnt_s = '0;
            end else if (gen_cnt > IDX_DW'(NSRC) - gen_base) begin
               eff_cnt_s = IDX_DW'(NSRC) - gen_base;
            end else begin
               eff_cnt_s = gen_cnt;
            end
         end
         default: begin
            base_s    = '0;
            eff_cnt_s = '0;
         end
      endcase
   end

   // first beat comes straight from the live sources; later beats from the snapshot
   always_comb begin
      if (state_r == ST_IDLE) begin
         place_word_s = pick(src_vec, base_s);
         place_lane_s = '0;
      end else begin
         place_word_s = pick(snap_r, base_r + k_r + IDX_DW'(1));
         place_lane_s = lane_next_s;
      end
   end

   cb_lane_place #(
      .L       (L),
      .DW      (RSA_DW),
      .LANE_DW (LANE_DW)
   ) u_place (
      .word (place_word_s),
      .lane (place_lane_s),
      .bus  (place_bus_s),
      .en   (place_en_s)
   );

   // sequencer FSM, beat counters, snapshot bank and registered outputs
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         state_r     <= ST_IDLE;
         snap_r      <= '0;
         base_r      <= '0;
         cnt_r       <= '0;
         k_r         <= '0;
         lane_r      <= '0;
         busy_r      <= 1'b0;
         out_valid_r <= 1'b0;
         dina_r      <= '0;
         wea_r       <= '0;
         lane_idx_r  <= '0;
         done_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start && mode_ok_s) begin
                  snap_r <= src_vec;
                  base_r <= base_s;
                  cnt_r  <= eff_cnt_s;
                  k_r    <= '0;
                  lane_r <= '0;
                  busy_r <= 1'b1;
                  if (eff_cnt_s == '0) begin
                     state_r <= ST_DONE;
                     done_r  <= 1'b1;
                  end else begin
                     state_r     <= ST_EMIT;
                     out_valid_r <= 1'b1;
                     dina_r      <= place_bus_s;
                     wea_r       <= place_en_s;
                     lane_idx_r  <= place_lane_s;
                  end
               end
            end
            ST_EMIT: begin
               if (out_valid_r && out_ready) begin
                  if (last_beat_s) begin
                     state_r     <= ST_DONE;
                     out_valid_r <= 1'b0;
                     dina_r      <= '0;
                     wea_r       <= '0;
                     lane_idx_r  <= '0;
                     done_r      <= 1'b1;
                  end else begin
                     k_r        <= k_r + IDX_DW'(1);
                     lane_r     <= lane_next_s;
                     dina_r     <= place_bus_s;
                     wea_r      <= place_en_s;
                     lane_idx_r <= place_lane_s;
                  end
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r     <= ST_IDLE;
               busy_r      <= 1'b0;
               out_valid_r <= 1'b0;
               dina_r      <= '0;
               wea_r       <= '0;
               lane_idx_r  <= '0;
               done_r      <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_r;
   assign out_valid = out_valid_r;
   assign CB_dina   = dina_r;
   assign CB_wea    = wea_r;
   assign lane_idx  = lane_idx_r;
   assign done      = done_r;

endmodule
